// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : Instruction fetch front end. Holds the PC, issues word       |
// |               fetches over a req/ready handshake, presents each fetched    |
// |               word to decode with valid/ready, and applies branch/jump     |
// |               redirects that drop any stale fetch or pending instruction.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam logic [31:0]      c_PC_STEP  = 32'd4;
    localparam logic [31:0]      c_RESET_PC = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_instr_pc;
    logic             r_req;
    logic             r_misalign;
    logic [CNT_W-1:0] r_cnt;

    logic             w_mem_accept;
    logic             w_dec_accept;
    logic             w_req_nxt;
    logic [31:0]      w_redirect_pc;

    assign w_redirect_pc = {redirect_target[31:2], 2'b00};

    // Next state and handshake decode; a redirect overrides every other transition.
    // The request register is still low in the first cycle after reset, so a
    // response arriving then is ignored even though the state is FETCH.
    always_comb begin
        w_state_nxt  = r_state;
        w_mem_accept = 1'b0;
        w_dec_accept = 1'b0;
        w_req_nxt    = 1'b0;
        case (r_state)
            FETCH: begin
                w_mem_accept = r_req & imem_ready & ~redirect_valid;
                if (w_mem_accept) begin
                    w_state_nxt = VALID;
                end
            end
            VALID: begin
                w_dec_accept = instr_ready;
                if (instr_ready) begin
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
        if (redirect_valid) begin
            w_state_nxt = FETCH;
        end
        w_req_nxt = (w_state_nxt == FETCH);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, request and instruction-holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= c_RESET_PC;
            r_req      <= 1'b0;
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
        end else begin
            r_req <= w_req_nxt;
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_mem_accept) begin
                r_pc       <= r_pc + c_PC_STEP;
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    // Sticky misalignment flag and accepted-instruction counter (counts a
    // decode handshake even when a redirect lands in the same cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end
            if (w_dec_accept) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_pc;
    assign instr_valid  = (r_state == VALID);
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_cnt;

endmodule
`default_nettype wire
